// File: rtl/regfile_param.sv
// regfile_param: parameterised register file, one write port and two independent
// combinational read ports; register 0 is hardwired to zero and always valid.
// Ports: clk/rst (async active-high), we/waddr/wdata write, ra/rb -> qa/qb + va/vb read,
// wcount = number of distinct registers written since reset.
// Latency: reads are zero-cycle; writes land on the rising clk edge. No backpressure.
// Option: define REGFILE_BYPASS_EN to forward wdata to a read port addressing the
// register being written in the same cycle (default build: no forwarding).
module regfile_param #(
  parameter  int size  = 8,
  parameter  int depth = 8,
  localparam int aw    = $clog2(depth)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [aw-1:0]   waddr,
  input  logic [size-1:0] wdata,
  input  logic [aw-1:0]   ra,
  input  logic [aw-1:0]   rb,
  output logic [size-1:0] qa,
  output logic [size-1:0] qb,
  output logic            va,
  output logic            vb,
  output logic [aw:0]     wcount
);

  localparam logic [aw:0] WC_MAX = (aw+1)'(depth - 1);
  localparam logic [aw:0] WC_ONE = (aw+1)'(1);

  logic [size-1:0] r_mem [depth];
  logic [depth-1:0] r_valid;
  logic [aw:0]      r_wcount;

  // Writes to address 0 are dropped entirely: no data, valid or count update.
  logic w_wr;
  assign w_wr = we && (waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        r_mem[i] <= '0;
      end
      r_valid  <= '0;
      r_wcount <= '0;
    end else if (w_wr) begin
      r_mem[waddr]   <= wdata;
      r_valid[waddr] <= 1'b1;
      // Count only first writes; the ceiling equals the number of writable
      // registers, so the guard only matters as a hard stop against wrap.
      if (!r_valid[waddr] && (r_wcount != WC_MAX)) begin
        r_wcount <= r_wcount + WC_ONE;
      end
    end
  end

  logic [size-1:0] w_qa, w_qb;
  logic            w_va, w_vb;

  always_comb begin
    w_qa = (ra == '0) ? '0   : r_mem[ra];
    w_va = (ra == '0) ? 1'b1 : r_valid[ra];
    w_qb = (rb == '0) ? '0   : r_mem[rb];
    w_vb = (rb == '0) ? 1'b1 : r_valid[rb];
`ifdef REGFILE_BYPASS_EN
    // w_wr already excludes address 0; rst blocks forwarding so reads show the
    // cleared state for the whole reset window.
    if (w_wr && !rst && (ra == waddr)) begin
      w_qa = wdata;
      w_va = 1'b1;
    end
    if (w_wr && !rst && (rb == waddr)) begin
      w_qb = wdata;
      w_vb = 1'b1;
    end
`endif
  end

  assign qa     = w_qa;
  assign qb     = w_qb;
  assign va     = w_va;
  assign vb     = w_vb;
  assign wcount = r_wcount;

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic [2:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic [2:0] ra = '0;
  logic [2:0] rb = '0;
  logic [7:0] qa, qb;
  logic       va, vb;
  logic [3:0] wcount;

  regfile_param #(.size(8), .depth(8)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .ra(ra), .rb(rb), .qa(qa), .qb(qb), .va(va), .vb(vb), .wcount(wcount)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Reference model: plain arrays of contents and written flags.
  int  m_mem [8];
  bit  m_wr  [8];
  int  n_chk = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit fwd(input int a);
    return BYP && !rst && we && (waddr != 0) && (a == int'(waddr));
  endfunction

  function automatic int exp_q(input int a);
    if (fwd(a)) return int'(wdata);
    if (a == 0) return 0;
    return m_mem[a];
  endfunction

  function automatic int exp_v(input int a);
    if (fwd(a) || a == 0) return 1;
    return m_wr[a] ? 1 : 0;
  endfunction

  // Distinct registers written = how many flags are set; register 0 never counts.
  function automatic int exp_cnt();
    int c = 0;
    for (int i = 1; i < 8; i++) c += m_wr[i] ? 1 : 0;
    return c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = 0;
      m_wr[i]  = 1'b0;
    end
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ".qa"}, int'(qa), exp_q(int'(ra)));
    chk({ph, ".qb"}, int'(qb), exp_q(int'(rb)));
    chk({ph, ".va"}, int'(va), exp_v(int'(ra)));
    chk({ph, ".vb"}, int'(vb), exp_v(int'(rb)));
    chk({ph, ".wcount"}, int'(wcount), exp_cnt());
  endtask

  // One clock: drive at negedge, check combinational view, clock, check again.
  task automatic cyc(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                     input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; ra = a; rb = b;
    #1 check_all("pre");
    @(posedge clk);
    if (!rst && we && waddr != 0) begin
      m_mem[waddr] = int'(wdata);
      m_wr[waddr]  = 1'b1;
    end
    #1 check_all("post");
  endtask

  // Reset asserted between edges, held across one edge with a write pending.
  task automatic mid_reset(input logic [2:0] a);
    @(negedge clk);
    ra = a; rb = 3'd0;
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("rst_now");
    we = 1'b1; waddr = 3'd5; wdata = 8'hEE; ra = 3'd5;
    @(posedge clk);
    #1 check_all("rst_hold");
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset pulse entirely between clock edges, then sweep every address.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all("por");
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i));

    // Basic write and readback; first write right after reset.
    cyc(1'b1, 3'd3, 8'hA5, 3'd3, 3'd7);
    cyc(1'b1, 3'd7, 8'h5A, 3'd3, 3'd7);
    cyc(1'b0, 3'd0, 8'h00, 3'd3, 3'd7);
    chk("dir.qa_A5", int'(qa), 8'hA5);
    chk("dir.qb_5A", int'(qb), 8'h5A);
    chk("dir.wcount2", int'(wcount), 2);

    // Register 0 ignores writes.
    cyc(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0);
    chk("zero.qa", int'(qa), 0);
    chk("zero.va", int'(va), 1);
    chk("zero.wcount", int'(wcount), 2);

    // Fill everything, rewrite r1: count sticks at 7.
    for (int i = 1; i < 8; i++) cyc(1'b1, 3'(i), 8'(8'h10 + i), 3'(i), 3'd1);
    cyc(1'b1, 3'd1, 8'h99, 3'd1, 3'd7);
    cyc(1'b1, 3'd1, 8'h98, 3'd1, 3'd1);
    chk("sat.wcount", int'(wcount), 7);

    // Same-cycle read/write on r4.
    cyc(1'b1, 3'd4, 8'h11, 3'd0, 3'd0);
    @(negedge clk);
    we = 1'b1; waddr = 3'd4; wdata = 8'h22; ra = 3'd4; rb = 3'd4;
    #1 chk("rdw.pre", int'(qa), BYP ? 8'h22 : 8'h11);
    chk("rdw.same", int'(qb), int'(qa));
    @(posedge clk);
    m_mem[4] = 8'h22;
    #1 chk("rdw.post", int'(qa), 8'h22);

    // Async reset mid-operation.
    cyc(1'b1, 3'd2, 8'h33, 3'd2, 3'd2);
    mid_reset(3'd2);
    chk("arst.wcount", int'(wcount), 0);
    cyc(1'b1, 3'd6, 8'h66, 3'd6, 3'd5);

    // Randomised traffic with occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) mid_reset(3'($urandom_range(0, 7)));
      else cyc(1'($urandom_range(0, 2) != 0), 3'($urandom), 8'($urandom),
               3'($urandom), 3'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
